// File: rtl/alu_ctrl_mdu_if.sv
// Bus between main control and the ALU-control / mult-div unit.
// The master is the CPU side, the slave is alu_ctrl_mdu.
interface alu_ctrl_mdu_if #(
  parameter int unsigned WIDTH = 32
);
  logic             op_valid;
  logic [2:0]       aluop;
  logic [5:0]       funct;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [3:0]       alu_ctrl;
  logic             stall;
  logic             md_done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output op_valid, aluop, funct, src_a, src_b,
    input  alu_ctrl, stall, md_done, hi, lo
  );

  modport slave (
    input  op_valid, aluop, funct, src_a, src_b,
    output alu_ctrl, stall, md_done, hi, lo
  );
endinterface

// File: rtl/alu_ctrl_mdu.sv
// ALU control decoder plus an optional multi-cycle mult/div sequencer with HI/LO.
// The sequencer is compiled only when ALUCTRL_MDU_EN is defined.
module alu_ctrl_mdu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic           clk,
  input logic           rst,
  alu_ctrl_mdu_if.slave bus
);
  localparam logic [3:0] OpAnd  = 4'b0000;
  localparam logic [3:0] OpOr   = 4'b0001;
  localparam logic [3:0] OpAdd  = 4'b0010;
  localparam logic [3:0] OpXor  = 4'b0011;
  localparam logic [3:0] OpNor  = 4'b0100;
  localparam logic [3:0] OpSll  = 4'b0101;
  localparam logic [3:0] OpSub  = 4'b0110;
  localparam logic [3:0] OpSlt  = 4'b0111;
  localparam logic [3:0] OpSltu = 4'b1000;
  localparam logic [3:0] OpSrl  = 4'b1001;
  localparam logic [3:0] OpSra  = 4'b1010;
  localparam logic [3:0] OpLui  = 4'b1011;
  localparam logic [3:0] OpNop  = 4'b1111;
`ifdef ALUCTRL_MDU_EN
  localparam logic [3:0] OpMfhi = 4'b1100;
  localparam logic [3:0] OpMflo = 4'b1101;
`endif

  logic [3:0] w_alu_ctrl;

  always_comb begin
    w_alu_ctrl = OpNop;
    unique case (bus.aluop)
      3'b000: w_alu_ctrl = OpAdd;
      3'b001: w_alu_ctrl = OpSub;
      3'b011: w_alu_ctrl = OpAnd;
      3'b100: w_alu_ctrl = OpOr;
      3'b101: w_alu_ctrl = OpXor;
      3'b110: w_alu_ctrl = OpSlt;
      3'b111: w_alu_ctrl = OpLui;
      3'b010: begin
        case (bus.funct)
          6'b100000, 6'b100001: w_alu_ctrl = OpAdd;
          6'b100010, 6'b100011: w_alu_ctrl = OpSub;
          6'b100100:            w_alu_ctrl = OpAnd;
          6'b100101:            w_alu_ctrl = OpOr;
          6'b100110:            w_alu_ctrl = OpXor;
          6'b100111:            w_alu_ctrl = OpNor;
          6'b101010:            w_alu_ctrl = OpSlt;
          6'b101011:            w_alu_ctrl = OpSltu;
          6'b000000:            w_alu_ctrl = OpSll;
          6'b000010:            w_alu_ctrl = OpSrl;
          6'b000011:            w_alu_ctrl = OpSra;
`ifdef ALUCTRL_MDU_EN
          6'b010000:            w_alu_ctrl = OpMfhi;
          6'b010010:            w_alu_ctrl = OpMflo;
`endif
          default:              w_alu_ctrl = OpNop;
        endcase
      end
      default: w_alu_ctrl = OpNop;
    endcase
  end

  assign bus.alu_ctrl = w_alu_ctrl;

`ifdef ALUCTRL_MDU_EN
  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_opd;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_neg_q, r_neg_r, r_dz, r_md_done;
  logic [WIDTH-1:0]   r_hi, r_lo;

  logic               w_start, w_signed, w_is_div, w_neg_a, w_neg_b, w_dz, w_last;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_quo, w_rem, w_res_hi, w_res_lo;
  logic [WIDTH:0]     w_mul_sum, w_div_trial;
  logic [2*WIDTH-1:0] w_mul_nxt, w_div_nxt, w_prod;

  // funct 0110xx: bit0 selects unsigned, bit1 selects divide
  assign w_start  = bus.op_valid && (bus.aluop == 3'b010) && (bus.funct[5:2] == 4'b0110);
  assign w_signed = !bus.funct[0];
  assign w_is_div = bus.funct[1];
  assign w_neg_a  = w_signed && bus.src_a[WIDTH-1];
  assign w_neg_b  = w_signed && bus.src_b[WIDTH-1];
  assign w_mag_a  = w_neg_a ? -bus.src_a : bus.src_a;
  assign w_mag_b  = w_neg_b ? -bus.src_b : bus.src_b;
  assign w_dz     = w_is_div && (bus.src_b == '0);
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opd} : '0);
  assign w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};
  assign w_prod    = r_neg_q ? -w_mul_nxt : w_mul_nxt;

  // Divide: acc = {partial remainder, dividend bits then quotient bits}
  assign w_div_trial = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]} - {1'b0, r_opd};
  assign w_div_nxt   = w_div_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                          : {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
  assign w_quo = w_div_nxt[WIDTH-1:0];
  assign w_rem = w_div_nxt[2*WIDTH-1:WIDTH];

  always_comb begin
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (r_state == StDiv) begin
      if (r_dz) begin
        w_res_hi = r_opd;
        w_res_lo = '1;
      end else begin
        w_res_hi = r_neg_r ? -w_rem : w_rem;
        w_res_lo = r_neg_q ? -w_quo : w_quo;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_opd     <= '0;
      r_acc     <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_dz      <= 1'b0;
      r_md_done <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_md_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_start) begin
            r_state <= w_is_div ? StDiv : StMul;
            r_cnt   <= '0;
            r_neg_q <= w_neg_a ^ w_neg_b;
            r_neg_r <= w_neg_a;
            r_dz    <= w_dz;
            // A zero divisor is irrelevant to the iteration, so the slot keeps raw src_a for hi
            r_opd   <= w_is_div ? (w_dz ? bus.src_a : w_mag_b) : w_mag_a;
            r_acc   <= {{WIDTH{1'b0}}, w_is_div ? w_mag_a : w_mag_b};
          end
        end
        StMul, StDiv: begin
          r_acc <= (r_state == StDiv) ? w_div_nxt : w_mul_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_state   <= StDone;
            r_hi      <= w_res_hi;
            r_lo      <= w_res_lo;
            r_md_done <= 1'b1;
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.stall   = !rst && ((r_state == StMul) || (r_state == StDiv) ||
                                ((r_state == StIdle) && w_start));
  assign bus.md_done = r_md_done;
  assign bus.hi      = r_hi;
  assign bus.lo      = r_lo;
`else
  logic w_unused;
  assign w_unused    = ^{clk, rst, bus.op_valid, bus.src_a, bus.src_b};
  assign bus.stall   = 1'b0;
  assign bus.md_done = 1'b0;
  assign bus.hi      = '0;
  assign bus.lo      = '0;
`endif
endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Randomized self-checking bench for alu_ctrl_mdu; follows ALUCTRL_MDU_EN like the design.
module tb_alu_ctrl_mdu;
`ifdef ALUCTRL_MDU_EN
  localparam bit MdEn = 1'b1;
`else
  localparam bit MdEn = 1'b0;
`endif
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  alu_ctrl_mdu_if #(.WIDTH(W)) bus ();

  alu_ctrl_mdu #(.WIDTH(W), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_ctrl(input logic [2:0] op, input logic [5:0] f);
    case (op)
      3'd0: return 4'h2;
      3'd1: return 4'h6;
      3'd3: return 4'h0;
      3'd4: return 4'h1;
      3'd5: return 4'h3;
      3'd6: return 4'h7;
      3'd7: return 4'hB;
      default: begin
        case (f)
          6'd32, 6'd33: return 4'h2;
          6'd34, 6'd35: return 4'h6;
          6'd36: return 4'h0;
          6'd37: return 4'h1;
          6'd38: return 4'h3;
          6'd39: return 4'h4;
          6'd42: return 4'h7;
          6'd43: return 4'h8;
          6'd0:  return 4'h5;
          6'd2:  return 4'h9;
          6'd3:  return 4'hA;
          6'd16: return MdEn ? 4'hC : 4'hF;
          6'd18: return MdEn ? 4'hD : 4'hF;
          default: return 4'hF;
        endcase
      end
    endcase
  endfunction

  // {hi, lo} from plain 64-bit arithmetic
  function automatic logic [63:0] md_model(input logic [5:0] f, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint sa, sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    case (f[1:0])
      2'd0: r = 64'(sa * sb);
      2'd1: r = {32'b0, a} * {32'b0, b};
      2'd2: if (b == 0) r = {a, 32'hFFFF_FFFF};
            else begin
              r[31:0]  = 32'(sa / sb);
              r[63:32] = 32'(sa % sb);
            end
      default: if (b == 0) r = {a, 32'hFFFF_FFFF};
               else r = {a % b, a / b};
    endcase
    return MdEn ? r : 64'd0;
  endfunction

  task automatic run_md(input string tag, input logic [5:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    logic [63:0] e;
    int n;
    e = md_model(f, a, b);
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.aluop    = 3'b010;
    bus.funct    = f;
    bus.src_a    = a;
    bus.src_b    = b;
    #1;
    check({tag, "/ctrl"}, 64'(bus.alu_ctrl), 64'hF);
    check({tag, "/hi_hold"}, 64'(bus.hi), 64'(exp_hi));
    n = 0;
    while (bus.stall && n < 100) begin
      @(negedge clk);
      bus.src_a = $urandom;  // operands must already be latched
      bus.src_b = $urandom;
      #1;
      n++;
    end
    check({tag, "/stall_cycles"}, 64'(n), MdEn ? 64'(W + 1) : 64'd0);
    if (n == 0) begin
      repeat (3) @(negedge clk);
      #1;
    end
    check({tag, "/md_done"}, 64'(bus.md_done), 64'(MdEn));
    exp_hi = e[63:32];
    exp_lo = e[31:0];
    check({tag, "/hi"}, 64'(bus.hi), 64'(exp_hi));
    check({tag, "/lo"}, 64'(bus.lo), 64'(exp_lo));
    @(negedge clk);
    bus.op_valid = 1'b0;
    #1;
    check({tag, "/done_pulse"}, 64'(bus.md_done), 64'd0);
    check({tag, "/idle_stall"}, 64'(bus.stall), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    logic [5:0] ff;
    logic [W-1:0] ra, rb;
    bus.op_valid = 1'b0;
    bus.aluop    = 3'b000;
    bus.funct    = 6'd0;
    bus.src_a    = '0;
    bus.src_b    = '0;
    #1;
    check("rst/stall", 64'(bus.stall), 64'd0);
    check("rst/md_done", 64'(bus.md_done), 64'd0);
    check("rst/hi", 64'(bus.hi), 64'd0);
    check("rst/lo", 64'(bus.lo), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Decode: fixed cases then random aluop/funct with op_valid low
    @(negedge clk);
    bus.aluop = 3'b010; bus.funct = 6'b100010; #1;
    check("dec/sub", 64'(bus.alu_ctrl), 64'h6);
    check("dec/sub_stall", 64'(bus.stall), 64'd0);
    bus.aluop = 3'b110; #1;
    check("dec/slt", 64'(bus.alu_ctrl), 64'h7);
    bus.aluop = 3'b010; bus.funct = 6'b111111; #1;
    check("dec/bad", 64'(bus.alu_ctrl), 64'hF);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      bus.aluop = 3'($urandom);
      bus.funct = (i % 2 == 0) ? 6'($urandom_range(0, 19)) : 6'($urandom_range(32, 47));
      bus.src_a = $urandom;
      #1;
      check("dec/rand", 64'(bus.alu_ctrl), 64'(exp_ctrl(bus.aluop, bus.funct)));
    end

    // Mult/div directed
    run_md("mult_neg", 6'b011000, 32'hFFFF_FFFD, 32'd7);
    run_md("multu_max", 6'b011001, 32'hFFFF_FFFF, 32'd2);
    run_md("divu", 6'b011011, 32'd100, 32'd7);
    run_md("div_neg", 6'b011010, 32'hFFFF_FFF9, 32'd2);
    run_md("div_zero", 6'b011010, 32'd5, 32'd0);
    run_md("divu_zero", 6'b011011, 32'h8000_0003, 32'd0);
    run_md("div_ovf", 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF);

    // Mult/div random
    for (int i = 0; i < 16; i++) begin
      ff = 6'b011000 | 6'($urandom_range(0, 3));
      ra = (i % 4 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      rb = (i % 5 == 0) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 9)) : $urandom);
      run_md("md_rand", ff, ra, rb);
    end

    // Reset in the middle of a MULT
    @(negedge clk);
    bus.op_valid = 1'b1; bus.aluop = 3'b010; bus.funct = 6'b011000;
    bus.src_a = 32'd3; bus.src_b = 32'd4;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort/stall", 64'(bus.stall), 64'd0);
    check("abort/hi", 64'(bus.hi), 64'd0);
    check("abort/lo", 64'(bus.lo), 64'd0);
    exp_hi = '0;
    exp_lo = '0;
    @(negedge clk);
    rst = 1'b0;
    bus.op_valid = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (bus.md_done) pulses++;
    end
    check("abort/no_done", 64'(pulses), 64'd0);
    run_md("after_abort", 6'b011011, 32'd9, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
